multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle LEGv8-style control unit: sequences FETCH/DECODE/EXEC/MEM/WB
// states, drives the datapath control lines and counts retired instructions.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   enable              run request (sampled in IDLE and at retirement)
//   opcode              instruction[31:21], valid from DECODE onward
//   mem_ready, zero     memory handshake and ALU zero flag
//   pc_write .. alu_op  datapath controls (combinational from state/inputs)
//   state               current state encoding
//   illegal, timeout    sticky error flags
//   instr_count         retired-instruction counter (wraps)
//
// Optional feature: define MULTICYCLE_CONTROL_TIMEOUT_EN to bound memory
// waits to TIMEOUT cycles (exceeding it traps to ERROR and sets timeout).
module multicycle_control #(
  parameter int unsigned OPCODE_WIDTH = 11,
  parameter int unsigned COUNT_WIDTH  = 16,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    mem_ready,
  input  logic                    zero,
  output logic                    pc_write,
  output logic                    ir_write,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    iord,
  output logic                    reg_write,
  output logic                    mem_to_reg,
  output logic                    reg2loc,
  output logic                    alu_src_a,
  output logic                    pc_src,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              alu_op,
  output logic [3:0]              state,
  output logic                    illegal,
  output logic                    timeout,
  output logic [COUNT_WIDTH-1:0]  instr_count
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_R   = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_ERROR  = 4'd15
  } state_t;

  // A zero TIMEOUT would make every memory access an immediate trap.
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("multicycle_control: TIMEOUT must be at least 1");
  end

  state_t cur, nxt;
  logic   is_r, is_ldur, is_stur, is_cbz;
  logic   retire_c, illegal_c, tmo_c;

  assign state = cur;

  // Opcode classification; CBZ matches on its top 8 bits only.
  always_comb begin
    is_r    = (opcode == OPCODE_WIDTH'(11'b10001011000)) ||
              (opcode == OPCODE_WIDTH'(11'b11001011000)) ||
              (opcode == OPCODE_WIDTH'(11'b10001010000)) ||
              (opcode == OPCODE_WIDTH'(11'b10101010000));
    is_ldur = (opcode == OPCODE_WIDTH'(11'b11111000010));
    is_stur = (opcode == OPCODE_WIDTH'(11'b11111000000));
    is_cbz  = (opcode[OPCODE_WIDTH-1 -: 8] == 8'b10110100);
  end

  assign illegal_c = (cur == S_DECODE) && !(is_r || is_ldur || is_stur || is_cbz);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cur <= S_IDLE;
    else       cur <= nxt;
  end

  // Next-state and datapath controls.
  always_comb begin
    nxt        = cur;
    retire_c   = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg2loc    = 1'b0;
    alu_src_a  = 1'b0;
    pc_src     = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (cur)
      S_IDLE: begin
        if (enable) nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        reg2loc   = is_stur || is_cbz;
        if (is_r)                   nxt = S_EXEC_R;
        else if (is_ldur || is_stur) nxt = S_ADDR;
        else if (is_cbz)            nxt = S_BRANCH;
        else                        nxt = S_ERROR;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        nxt       = S_WB_R;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        retire_c  = 1'b1;
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        reg2loc   = is_stur;
        nxt       = is_stur ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) nxt = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire_c   = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        reg2loc   = 1'b1;
        retire_c  = mem_ready;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        reg2loc   = 1'b1;
        pc_src    = 1'b1;
        pc_write  = zero;
        retire_c  = 1'b1;
      end
      S_ERROR: nxt = S_ERROR;
      default: nxt = S_IDLE;
    endcase
    if (retire_c) nxt = enable ? S_FETCH : S_IDLE;
    if (tmo_c)    nxt = S_ERROR;
  end

  // Retired-instruction counter, wraps naturally at its width.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         instr_count <= '0;
    else if (retire_c) instr_count <= instr_count + COUNT_WIDTH'(1);
  end

  // Sticky illegal-opcode flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          illegal <= 1'b0;
    else if (illegal_c) illegal <= 1'b1;
  end

`ifdef MULTICYCLE_CONTROL_TIMEOUT_EN
  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic              waiting_c;
  logic [WAIT_W-1:0] wait_cnt;

  assign waiting_c = (cur == S_FETCH) || (cur == S_MEM_RD) || (cur == S_MEM_WR);
  assign tmo_c     = waiting_c && !mem_ready && (wait_cnt == WAIT_LAST);

  // Wait counter restarts on every state change, so each wait state starts at 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                        wait_cnt <= '0;
    else if (nxt != cur)              wait_cnt <= '0;
    else if (waiting_c && !mem_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  // Sticky memory-timeout flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      timeout <= 1'b0;
    else if (tmo_c) timeout <= 1'b1;
  end
`else
  assign tmo_c   = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control. A second instance
// with COUNT_WIDTH=4 shares the stimulus to exercise counter wrap.
module tb_multicycle_control;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;

  // {pc_write,ir_write,mem_read,mem_write,iord,reg_write,mem_to_reg,
  //  reg2loc,alu_src_a,pc_src,alu_src_b[1:0],alu_op[1:0]}
  localparam logic [13:0] C_ZERO    = 14'b0_0_0_0_0_0_0_0_0_0_00_00;
  localparam logic [13:0] C_FETCH_R = 14'b1_1_1_0_0_0_0_0_0_0_01_00;
  localparam logic [13:0] C_FETCH_W = 14'b0_0_1_0_0_0_0_0_0_0_01_00;
  localparam logic [13:0] C_DEC     = 14'b0_0_0_0_0_0_0_0_0_0_11_00;
  localparam logic [13:0] C_DEC_R2L = 14'b0_0_0_0_0_0_0_1_0_0_11_00;
  localparam logic [13:0] C_EXEC_R  = 14'b0_0_0_0_0_0_0_0_1_0_00_10;
  localparam logic [13:0] C_WB_R    = 14'b0_0_0_0_0_1_0_0_0_0_00_00;
  localparam logic [13:0] C_ADDR_LD = 14'b0_0_0_0_0_0_0_0_1_0_10_00;
  localparam logic [13:0] C_ADDR_ST = 14'b0_0_0_0_0_0_0_1_1_0_10_00;
  localparam logic [13:0] C_MEM_RD  = 14'b0_0_1_0_1_0_0_0_0_0_00_00;
  localparam logic [13:0] C_WB_MEM  = 14'b0_0_0_0_0_1_1_0_0_0_00_00;
  localparam logic [13:0] C_MEM_WR  = 14'b0_0_0_1_1_0_0_1_0_0_00_00;
  localparam logic [13:0] C_BR_Z1   = 14'b1_0_0_0_0_0_0_1_1_1_00_01;
  localparam logic [13:0] C_BR_Z0   = 14'b0_0_0_0_0_0_0_1_1_1_00_01;

  logic        clock, reset, enable, mem_ready, zero;
  logic [10:0] opcode;
  logic        pc_write, ir_write, mem_read, mem_write, iord, reg_write;
  logic        mem_to_reg, reg2loc, alu_src_a, pc_src;
  logic [1:0]  alu_src_b, alu_op;
  logic [3:0]  state;
  logic        illegal, timeout;
  logic [15:0] instr_count;
  logic        pc_write2, ir_write2, mem_read2, mem_write2, iord2, reg_write2;
  logic        mem_to_reg2, reg2loc2, alu_src_a2, pc_src2;
  logic [1:0]  alu_src_b2, alu_op2;
  logic [3:0]  state2;
  logic        illegal2, timeout2;
  logic [3:0]  count4;
  logic [13:0] ctrl, ctrl2;

  int errors = 0;
  int checks = 0;

  assign ctrl  = {pc_write, ir_write, mem_read, mem_write, iord, reg_write,
                  mem_to_reg, reg2loc, alu_src_a, pc_src, alu_src_b, alu_op};
  assign ctrl2 = {pc_write2, ir_write2, mem_read2, mem_write2, iord2, reg_write2,
                  mem_to_reg2, reg2loc2, alu_src_a2, pc_src2, alu_src_b2, alu_op2};

  multicycle_control dut (
    .clock(clock), .reset(reset), .enable(enable), .opcode(opcode),
    .mem_ready(mem_ready), .zero(zero),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .reg2loc(reg2loc), .alu_src_a(alu_src_a),
    .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .state(state), .illegal(illegal), .timeout(timeout),
    .instr_count(instr_count)
  );

  multicycle_control #(.COUNT_WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .enable(enable), .opcode(opcode),
    .mem_ready(mem_ready), .zero(zero),
    .pc_write(pc_write2), .ir_write(ir_write2), .mem_read(mem_read2),
    .mem_write(mem_write2), .iord(iord2), .reg_write(reg_write2),
    .mem_to_reg(mem_to_reg2), .reg2loc(reg2loc2), .alu_src_a(alu_src_a2),
    .pc_src(pc_src2), .alu_src_b(alu_src_b2), .alu_op(alu_op2),
    .state(state2), .illegal(illegal2), .timeout(timeout2),
    .instr_count(count4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Holds reset for two edges; returns at posedge+1 in IDLE.
  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = '0;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = '0;
    #2;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (ctrl !== C_ZERO) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, C_ZERO); end
    checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", instr_count); end
    checks++; if ({illegal, timeout} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {illegal, timeout}); end
    @(posedge clock); #1; reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL idle_hold: got %0d expected 0", state); end
    enable = 1'b1; #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL idle_no_edge: got %0d expected 0", state); end
    @(posedge clock); #1;
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL idle_to_fetch: got %0d expected 1", state); end
  endtask

  task automatic test_add();
    logic [3:0]  es [6];
    logic [13:0] ec [6];
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd1};
    ec = '{C_ZERO, C_FETCH_R, C_DEC, C_EXEC_R, C_WB_R, C_FETCH_R};
    do_reset();
    opcode = OP_ADD; mem_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (state !== es[i]) begin errors++; $display("FAIL add_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      checks++; if (ctrl !== ec[i]) begin errors++; $display("FAIL add_ctrl[%0d]: got %b expected %b", i, ctrl, ec[i]); end
      @(posedge clock); #1;
    end
    checks++; if (instr_count !== 16'd1) begin errors++; $display("FAIL add_count: got %0d expected 1", instr_count); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] ops [3];
    logic [3:0]  es [4];
    logic [13:0] ec [4];
    ops = '{OP_SUB, OP_AND, OP_ORR};
    es  = '{4'd1, 4'd2, 4'd3, 4'd7};
    ec  = '{C_FETCH_R, C_DEC, C_EXEC_R, C_WB_R};
    do_reset();
    mem_ready = 1'b1; enable = 1'b1;
    @(posedge clock); #1;
    for (int k = 0; k < 3; k++) begin
      opcode = ops[k];
      for (int i = 0; i < 4; i++) begin
        #1;
        checks++; if (state !== es[i]) begin errors++; $display("FAIL b2b_state[%0d][%0d]: got %0d expected %0d", k, i, state, es[i]); end
        checks++; if (ctrl !== ec[i]) begin errors++; $display("FAIL b2b_ctrl[%0d][%0d]: got %b expected %b", k, i, ctrl, ec[i]); end
        @(posedge clock); #1;
      end
    end
    checks++; if (instr_count !== 16'd3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", instr_count); end
  endtask

  task automatic test_ldur();
    logic [3:0]  es [10];
    logic [13:0] ec [10];
    logic        mr [10];
    es = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5, 4'd8, 4'd1};
    ec = '{C_ZERO, C_FETCH_R, C_DEC, C_ADDR_LD, C_MEM_RD, C_MEM_RD, C_MEM_RD,
           C_MEM_RD, C_WB_MEM, C_FETCH_R};
    mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    opcode = OP_LDUR; enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mem_ready = mr[i];
      #1;
      checks++; if (state !== es[i]) begin errors++; $display("FAIL ldur_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      checks++; if (ctrl !== ec[i]) begin errors++; $display("FAIL ldur_ctrl[%0d]: got %b expected %b", i, ctrl, ec[i]); end
      @(posedge clock); #1;
    end
    checks++; if (instr_count !== 16'd1) begin errors++; $display("FAIL ldur_count: got %0d expected 1", instr_count); end
  endtask

  task automatic test_stur();
    logic [3:0]  es [7];
    logic [13:0] ec [7];
    logic        mr [7];
    es = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd6, 4'd1};
    ec = '{C_ZERO, C_FETCH_W, C_DEC_R2L, C_ADDR_ST, C_MEM_WR, C_MEM_WR, C_FETCH_R};
    mr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    opcode = OP_STUR; enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr[i];
      // one stalled fetch cycle before the fetch completes
      if (i == 2) begin
        #1;
        checks++; if (state !== 4'd1) begin errors++; $display("FAIL stur_fetch_wait: got %0d expected 1", state); end
        @(posedge clock); #1;
      end
      #1;
      checks++; if (state !== es[i]) begin errors++; $display("FAIL stur_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      checks++; if (ctrl !== ec[i]) begin errors++; $display("FAIL stur_ctrl[%0d]: got %b expected %b", i, ctrl, ec[i]); end
      if (i != 1) begin @(posedge clock); #1; end
    end
    checks++; if (instr_count !== 16'd1) begin errors++; $display("FAIL stur_count: got %0d expected 1", instr_count); end
  endtask

  task automatic test_cbz();
    logic [3:0]  es [8];
    logic [13:0] ec [8];
    logic        zz [8];
    es = '{4'd0, 4'd1, 4'd2, 4'd9, 4'd1, 4'd2, 4'd9, 4'd1};
    ec = '{C_ZERO, C_FETCH_R, C_DEC_R2L, C_BR_Z1, C_FETCH_R, C_DEC_R2L, C_BR_Z0, C_FETCH_R};
    zz = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    opcode = OP_CBZ; mem_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      zero = zz[i];
      #1;
      checks++; if (state !== es[i]) begin errors++; $display("FAIL cbz_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      checks++; if (ctrl !== ec[i]) begin errors++; $display("FAIL cbz_ctrl[%0d]: got %b expected %b", i, ctrl, ec[i]); end
      @(posedge clock); #1;
    end
    checks++; if (instr_count !== 16'd2) begin errors++; $display("FAIL cbz_count: got %0d expected 2", instr_count); end
  endtask

  task automatic test_illegal();
    logic [10:0] ops [2];
    ops = '{11'b00000000000, 11'b10001011001};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      opcode = ops[k]; mem_ready = 1'b1; enable = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      checks++; if ({state, ctrl} !== {4'd2, C_DEC}) begin errors++; $display("FAIL illegal_decode[%0d]: got %0d/%b expected 2/%b", k, state, ctrl, C_DEC); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_early[%0d]: got %b expected 0", k, illegal); end
      @(posedge clock); #1;
      for (int i = 0; i < 20; i++) begin
        enable = i[0];
        #1;
        checks++; if ({state, ctrl, illegal} !== {4'd15, C_ZERO, 1'b1}) begin errors++; $display("FAIL illegal_hold[%0d][%0d]: got %0d/%b/%b expected 15/%b/1", k, i, state, ctrl, illegal, C_ZERO); end
        @(posedge clock); #1;
      end
      reset = 1'b1; #1;
      checks++; if ({state, illegal} !== {4'd0, 1'b0}) begin errors++; $display("FAIL illegal_reset[%0d]: got %0d/%b expected 0/0", k, state, illegal); end
      reset = 1'b0;
    end
  endtask

  task automatic test_reset_midwait();
    do_reset();
    opcode = OP_ADD; mem_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 5; i++) begin @(posedge clock); #1; end
    opcode = OP_LDUR;
    @(posedge clock); #1;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clock); #1; end
    checks++; if ({state, instr_count} !== {4'd5, 16'd1}) begin errors++; $display("FAIL midwait_pre: got %0d/%0d expected 5/1", state, instr_count); end
    #2; reset = 1'b1; #1;
    checks++; if ({state, instr_count, ctrl} !== {4'd0, 16'd0, C_ZERO}) begin errors++; $display("FAIL midwait_reset: got %0d/%0d/%b expected 0/0/%b", state, instr_count, ctrl, C_ZERO); end
    @(posedge clock); #1; reset = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    opcode = OP_ADD; mem_ready = 1'b0; enable = 1'b1;
    @(posedge clock); #1;
`ifdef MULTICYCLE_CONTROL_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      #1;
      checks++; if ({state, timeout} !== {4'd1, 1'b0}) begin errors++; $display("FAIL tmo_wait[%0d]: got %0d/%b expected 1/0", i, state, timeout); end
      @(posedge clock); #1;
    end
    checks++; if ({state, timeout, illegal} !== {4'd15, 1'b1, 1'b0}) begin errors++; $display("FAIL tmo_trap: got %0d/%b/%b expected 15/1/0", state, timeout, illegal); end
`else
    for (int i = 0; i < 100; i++) begin
      #1;
      checks++; if ({state, timeout, ctrl} !== {4'd1, 1'b0, C_FETCH_W}) begin errors++; $display("FAIL nowait_tmo[%0d]: got %0d/%b/%b expected 1/0/%b", i, state, timeout, ctrl, C_FETCH_W); end
      @(posedge clock); #1;
    end
`endif
  endtask

  task automatic test_wrap();
    do_reset();
    opcode = OP_ORR; mem_ready = 1'b1; enable = 1'b1;
    @(posedge clock); #1;
    for (int k = 1; k <= 16; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (k == 16 && c == 3) enable = 1'b0;
        @(posedge clock); #1;
      end
      if (k == 15) begin
        checks++; if ({count4, instr_count} !== {4'd15, 16'd15}) begin errors++; $display("FAIL wrap_15: got %0d/%0d expected 15/15", count4, instr_count); end
      end
    end
    checks++; if (count4 !== 4'd0) begin errors++; $display("FAIL wrap_0: got %0d expected 0", count4); end
    checks++; if (instr_count !== 16'd16) begin errors++; $display("FAIL wrap_count16: got %0d expected 16", instr_count); end
    @(posedge clock); #1;
    checks++; if ({state, state2} !== {4'd0, 4'd0}) begin errors++; $display("FAIL wrap_idle: got %0d/%0d expected 0/0", state, state2); end
    checks++; if ({ctrl2, illegal2, timeout2} !== {C_ZERO, 2'b00}) begin errors++; $display("FAIL wrap_idle_out: got %b/%b/%b expected %b/0/0", ctrl2, illegal2, timeout2, C_ZERO); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_ldur();
    test_stur();
    test_cbz();
    test_illegal();
    test_reset_midwait();
    test_timeout();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case a wait above never returns.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
